seg_disp_sched: RTL and testbench
=================================

Name: seg_disp_sched

Overview:
- Scheduler and formatter in front of the `sevenseg` 4-digit multiplexer of the PWM project.
- Arbitrates between two requesters (A: duty-cycle value, B: frequency/period value) that share one display.
- Converts the granted binary value to 4 BCD digits with a sequential double-dabble engine, and applies leading-zero blanking and overflow marking.
- Presents digit0..digit3 registered and updated atomically; these drive in0..in3 of `sevenseg`.

Parameters:
- W, 14: width of the binary request values (maximum 16383).
- BLANK_LZ, 1: 1 = suppress leading zeros; 0 = show all four digits.
- BLANK_CODE, 4'd15: digit code driven for a suppressed leading zero.
- OVF_CODE, 4'd10: digit code driven on all four digits when the value exceeds 9999.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- req_a  in  1  requester A wants display; level, held until ack_a.
- val_a  in  W  requester A value; must be stable while req_a is high.
- ack_a  out 1  one-cycle pulse: A's value captured.
- req_b  in  1  requester B request; same rules as A.
- val_b  in  W  requester B value.
- ack_b  out 1  one-cycle pulse: B's value captured.
- busy   out 1  high while a conversion is in flight (SHIFT or COMMIT).
- owner  out 1  source of the currently displayed value: 0 = A, 1 = B.
- overflow out 1  high while the displayed value is greater than 9999.
- digit0 out 4  units digit code (to in0).
- digit1 out 4  tens digit code (to in1).
- digit2 out 4  hundreds digit code (to in2).
- digit3 out 4  thousands digit code (to in3).

Behaviour:
- Clocking and reset:
  - One clock, `clock`.
  - `reset` is synchronous and active-high, sampled on the rising edge of `clock`.
  - Reset has priority over everything, including a conversion mid-flight; that conversion is discarded and no ack is issued for it.
- Reset values:
  - state = IDLE; ack_a = ack_b = 0; busy = 0; overflow = 0; owner = 0.
  - last_grant = B, so A wins the first tie.
  - digit0 = 4'd0.
  - digit1..3 = BLANK_CODE if BLANK_LZ = 1, else 4'd0.
- States: IDLE, SHIFT, COMMIT.
- IDLE:
  - At an edge where reset = 0 and (req_a | req_b), choose the grant:
    - only one request high: grant it;
    - both high: grant the source that is not last_grant (round-robin).
  - On that edge: capture the granted value into the shift register; clear the BCD accumulator (5 digits / 20 bits); set the iteration counter to W; pulse the granted ack high for exactly the next cycle; set busy; go to SHIFT.
  - No requests: stay in IDLE; all outputs hold.
- SHIFT:
  - Each cycle, every BCD nibble that is ≥5 gets +3 added, then {bcd, bin} shifts left by 1; the counter decrements.
  - After W shift cycles, go to COMMIT.
  - Requests arriving in SHIFT or COMMIT are not acked; they stay pending.
- COMMIT (one cycle):
  - Register digit0..3 from BCD nibbles 0..3 and set owner = granted source.
  - If nibble 4 ≠ 0: all four digits = OVF_CODE and overflow = 1; otherwise overflow = 0.
  - Blanking (BLANK_LZ = 1, no overflow): a digit k ≥ 1 becomes BLANK_CODE when it and all higher digits are 0. Digit0 is never blanked.
  - Update last_grant; clear busy; return to IDLE.
- Latency:
  - Grant edge T: ack visible during cycle T+1.
  - Digits, owner and overflow change on edge T+W+1 (T+15 at the default W).
  - Back-to-back throughput: W+2 cycles per conversion.
- Requests in IDLE are sampled on the grant edge: a request dropped before any grant edge is never acked. A requester holding req high after its ack is granted again on the next IDLE edge.
- The digit outputs never show partial results: all four change on the same edge.

Decomposition:
- Shared package `seg_pkg`:
  - state enum {IDLE, SHIFT, COMMIT};
  - BLANK_CODE and OVF_CODE constants, shared with the `sevenseg` decode table;
  - BCD_DIGITS = 5.
- One natural sub-module, `bcd_dd_step`: combinational add-3-then-shift step over 5 nibbles plus the binary register. It is instanced once; the FSM reuses it every cycle.

Test Plan:
1. Reset; then req_a = 1 with val_a = 1234 → ack_a pulse at T+1; at T+15 digits {3..0} = {1,2,3,4}, owner = 0, overflow = 0, busy = 0.
2. val_b = 7, BLANK_LZ = 1 → digits {15,15,15,7}. Then val_b = 0 → digits {15,15,15,0}. With BLANK_LZ = 0 → {0,0,0,7}.
3. val_a = 10000, then val_a = 16383 → all digits = 10, overflow = 1. Then val_a = 9999 → digits {9,9,9,9}, overflow = 0.
4. req_a and req_b held high continuously, val_a = 1, val_b = 2 → grants alternate A, B, A, B, every 16 cycles, A first after reset; owner toggles accordingly.
5. Assert reset on the 5th SHIFT cycle of a val_a = 4321 conversion → next cycle digits return to reset values with no COMMIT or further ack; req_a still high then gets ack_a at the 2nd edge after reset release.
6. req_b asserted during cycle T+3 of an A conversion → no ack_b until IDLE; ack_b appears at T+17.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared state encoding and digit codes for the display scheduler and sevenseg decode
package seg_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;
  localparam logic [3:0] BLANK_CODE = 4'd15;
  localparam logic [3:0] OVF_CODE = 4'd10;
  localparam int BCD_DIGITS = 5;
endpackage

// File: rtl/bcd_dd_step.sv
// bcd_dd_step: one double-dabble iteration, add-3 on nibbles >= 5 then shift {bcd, bin} left
module bcd_dd_step import seg_pkg::*; #(
  parameter int W = 14,
  parameter int N = BCD_DIGITS
) (
  input  logic [4*N-1:0] bcd_i,
  input  logic [W-1:0]   bin_i,
  output logic [4*N-1:0] bcd_o,
  output logic [W-1:0]   bin_o
);
  logic [4*N-1:0] adj;
  for (genvar i = 0; i < N; i++) begin : g_adj
    assign adj[4*i+:4] = bcd_i[4*i+:4] >= 4'd5 ? bcd_i[4*i+:4] + 4'd3 : bcd_i[4*i+:4];
  end
  assign {bcd_o, bin_o} = {adj, bin_i} << 1;
endmodule

// File: rtl/seg_disp_sched.sv
// seg_disp_sched: round-robin display arbiter with sequential binary-to-BCD conversion and blanking
module seg_disp_sched #(
  parameter int         W          = 14,
  parameter bit         BLANK_LZ   = 1'b1,
  parameter logic [3:0] BLANK_CODE = seg_pkg::BLANK_CODE,
  parameter logic [3:0] OVF_CODE   = seg_pkg::OVF_CODE
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_a,
  input  logic [W-1:0] val_a,
  output logic         ack_a,
  input  logic         req_b,
  input  logic [W-1:0] val_b,
  output logic         ack_b,
  output logic         busy,
  output logic         owner,
  output logic         overflow,
  output logic [3:0]   digit0,
  output logic [3:0]   digit1,
  output logic [3:0]   digit2,
  output logic [3:0]   digit3
);
  import seg_pkg::*;
  localparam int BW = 4*BCD_DIGITS;
  localparam int CW = $clog2(W+1);
  state_e state_q;
  logic [BW-1:0] bcd_q, bcd_d;
  logic [W-1:0] bin_q, bin_d;
  logic [CW-1:0] cnt_q;
  logic last_q, src_q, ack_a_q, ack_b_q, busy_q, owner_q, ovf_q;
  logic [15:0] dig_q, dig_d;
  logic grant_b, ovf_d, z3, z2, z1;
  bcd_dd_step #(.W(W), .N(BCD_DIGITS)) u_step (
    .bcd_i(bcd_q),
    .bin_i(bin_q),
    .bcd_o(bcd_d),
    .bin_o(bin_d)
  );
  // on a tie, the source that did not win last time gets the display
  assign grant_b = req_b & (~req_a | ~last_q);
  assign ovf_d = |bcd_q[19:16];
  assign z3 = bcd_q[15:12] == 4'd0;
  assign z2 = z3 && bcd_q[11:8] == 4'd0;
  assign z1 = z2 && bcd_q[7:4] == 4'd0;
  assign dig_d = ovf_d ? {4{OVF_CODE}} :
                 {BLANK_LZ && z3 ? BLANK_CODE : bcd_q[15:12],
                  BLANK_LZ && z2 ? BLANK_CODE : bcd_q[11:8],
                  BLANK_LZ && z1 ? BLANK_CODE : bcd_q[7:4],
                  bcd_q[3:0]};
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      src_q   <= 1'b0;
      last_q  <= 1'b1;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      busy_q  <= 1'b0;
      owner_q <= 1'b0;
      ovf_q   <= 1'b0;
      dig_q   <= {{3{BLANK_LZ ? BLANK_CODE : 4'd0}}, 4'd0};
    end else begin
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      case (state_q)
        IDLE: if (req_a | req_b) begin
          src_q   <= grant_b;
          bin_q   <= grant_b ? val_b : val_a;
          bcd_q   <= '0;
          cnt_q   <= CW'(W);
          ack_a_q <= ~grant_b;
          ack_b_q <= grant_b;
          busy_q  <= 1'b1;
          state_q <= SHIFT;
        end
        SHIFT: begin
          bcd_q   <= bcd_d;
          bin_q   <= bin_d;
          cnt_q   <= cnt_q - CW'(1);
          state_q <= cnt_q == CW'(1) ? COMMIT : SHIFT;
        end
        COMMIT: begin
          dig_q   <= dig_d;
          ovf_q   <= ovf_d;
          owner_q <= src_q;
          last_q  <= src_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ack_a = ack_a_q;
  assign ack_b = ack_b_q;
  assign busy = busy_q;
  assign owner = owner_q;
  assign overflow = ovf_q;
  assign {digit3, digit2, digit1, digit0} = dig_q;
endmodule

// File: tb/tb_seg_disp_sched.sv
// tb_seg_disp_sched: directed checks of arbitration, conversion, blanking, overflow and reset abort
module tb_seg_disp_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_a = 1'b0, req_b = 1'b0;
  logic [13:0] val_a = '0, val_b = '0;
  logic ack_a, ack_b, busy, owner, ovf;
  logic [3:0] d0, d1, d2, d3;
  logic ack_a_z, ack_b_z, busy_z, owner_z, ovf_z;
  logic [3:0] z0, z1, z2, z3;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  seg_disp_sched dut (
    .clock(clk), .reset(rst),
    .req_a(req_a), .val_a(val_a), .ack_a(ack_a),
    .req_b(req_b), .val_b(val_b), .ack_b(ack_b),
    .busy(busy), .owner(owner), .overflow(ovf),
    .digit0(d0), .digit1(d1), .digit2(d2), .digit3(d3)
  );
  seg_disp_sched #(.BLANK_LZ(1'b0)) dut_nb (
    .clock(clk), .reset(rst),
    .req_a(req_a), .val_a(val_a), .ack_a(ack_a_z),
    .req_b(req_b), .val_b(val_b), .ack_b(ack_b_z),
    .busy(busy_z), .owner(owner_z), .overflow(ovf_z),
    .digit0(z0), .digit1(z1), .digit2(z2), .digit3(z3)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic run(input bit b, input logic [13:0] v, input logic [15:0] ed, input bit eo);
    @(negedge clk);
    if (b) begin req_b = 1'b1; val_b = v; end
    else begin req_a = 1'b1; val_a = v; end
    @(posedge clk);
    @(negedge clk);
    req_a = 1'b0;
    req_b = 1'b0;
    chk("ack", b ? ack_b : ack_a, 1);
    chk("busy_on", busy, 1);
    repeat (14) @(posedge clk);
    @(negedge clk);
    chk("busy_mid", busy, 1);
    @(posedge clk);
    @(negedge clk);
    chk("digits", {d3, d2, d1, d0}, ed);
    chk("ovf", ovf, eo);
    chk("owner", owner, b);
    chk("busy_off", busy, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_digits", {d3, d2, d1, d0}, 16'hFFF0);
    chk("rst_digits_nb", {z3, z2, z1, z0}, 16'h0000);
    chk("rst_busy", busy, 0);
    chk("rst_ack", {ack_a, ack_b}, 0);
    chk("rst_owner_ovf", {owner, ovf}, 0);
    rst = 1'b0;
    run(1'b0, 14'd1234, 16'h1234, 1'b0);
    run(1'b1, 14'd7, 16'hFFF7, 1'b0);
    chk("nb_7", {z3, z2, z1, z0}, 16'h0007);
    run(1'b1, 14'd0, 16'hFFF0, 1'b0);
    chk("nb_0", {z3, z2, z1, z0}, 16'h0000);
    run(1'b0, 14'd10000, 16'hAAAA, 1'b1);
    run(1'b0, 14'd16383, 16'hAAAA, 1'b1);
    run(1'b0, 14'd9999, 16'h9999, 1'b0);
    run(1'b0, 14'd1020, 16'h1020, 1'b0);
    chk("nb_1020", {z3, z2, z1, z0}, 16'h1020);
    run(1'b1, 14'd305, 16'hF305, 1'b0);
    // round-robin with both requesters held high, A first after reset
    do_reset();
    req_a = 1'b1; val_a = 14'd1;
    req_b = 1'b1; val_b = 14'd2;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rr_ack", {ack_a, ack_b}, (k % 2) ? 2'b01 : 2'b10);
      repeat (15) @(posedge clk);
      @(negedge clk);
      chk("rr_owner", owner, k % 2);
      chk("rr_digits", {d3, d2, d1, d0}, (k % 2) ? 16'hFFF2 : 16'hFFF1);
    end
    req_a = 1'b0;
    req_b = 1'b0;
    // reset sampled on the 5th shift edge aborts the conversion
    @(negedge clk);
    req_a = 1'b1; val_a = 14'd4321;
    @(posedge clk);
    @(negedge clk);
    chk("ab_ack", ack_a, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ab_digits", {d3, d2, d1, d0}, 16'hFFF0);
    chk("ab_state", {busy, owner, ovf, ack_a, ack_b}, 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ab_reack", ack_a, 1);
    req_a = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("ab_digits2", {d3, d2, d1, d0}, 16'h4321);
    // B request arriving mid-conversion waits for IDLE
    @(negedge clk);
    req_a = 1'b1; val_a = 14'd5;
    @(posedge clk);
    @(negedge clk);
    req_a = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_b = 1'b1; val_b = 14'd8;
    for (int i = 3; i <= 16; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 15) chk("pend_digits", {d3, d2, d1, d0}, 16'hFFF5);
      chk("pend_ackb", ack_b, i == 16);
    end
    req_b = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("pend_final", {owner, d3, d2, d1, d0}, 20'h1FFF8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
